// File: rtl/rem_recon.sv
// rem_recon: rebuilds a dividend P = Q*B + R with a 3-cycle shift-add
// multiplier over the operand magnitudes, followed by a sign fix-up.
module rem_recon (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic       [2:0] Q,
  input  logic       [2:0] B,
  input  logic       [4:0] R,
  output logic       [5:0] P,
  output logic             busy,
  output logic             done,
  output logic             DZF,
  output logic             SF,
  output logic             ZF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       load;

  logic [2:0] q_r;
  logic [2:0] b_r;
  logic [4:0] r_r;
  logic [4:0] acc;
  logic [1:0] cnt;

  logic [2:0] q_mag;
  logic [2:0] b_mag;
  logic [4:0] addend;
  logic       neg;
  logic       bz;
  logic [5:0] prod;
  logic [5:0] sprod;
  logic [5:0] sum;
  logic [5:0] result;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CALC;
          load    = 1'b1;
        end
      end
      CALC: if (cnt == 2'd2) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // |-4| wraps to 3'b100, which reads correctly as unsigned 4
  assign q_mag  = q_r[2] ? -q_r : q_r;
  assign b_mag  = b_r[2] ? -b_r : b_r;
  assign addend = q_mag[cnt] ? ({2'b00, b_mag} << cnt) : 5'd0;

  assign neg    = q_r[2] ^ b_r[2];
  assign bz     = (b_r == 3'd0);
  assign prod   = {1'b0, acc};
  assign sprod  = neg ? -prod : prod;
  assign sum    = sprod + {r_r[4], r_r};
  assign result = bz ? 6'd0 : sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r  <= '0;
      b_r  <= '0;
      r_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      P    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      DZF  <= 1'b0;
      SF   <= 1'b0;
      ZF   <= 1'b0;
    end else begin
      // strobes trail the state by one edge so start-to-done is 4 cycles
      busy <= (state == CALC);
      done <= (state == DONE);
      if (load) begin
        q_r <= Q;
        b_r <= B;
        r_r <= R;
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc + addend;
        cnt <= cnt + 2'd1;
      end
      if (state == DONE) begin
        P   <= result;
        SF  <= result[5];
        ZF  <= (result == 6'd0);
        DZF <= bz;
      end
    end
  end

endmodule

// File: tb/tb_rem_recon.sv
// tb_rem_recon: vector table, exhaustive sweep, randomized ops and
// reset/throughput sequences against an integer Q*B+R model.
module tb_rem_recon;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] Q;
  logic [2:0] B;
  logic [4:0] R;
  logic [5:0] P;
  logic       busy;
  logic       done;
  logic       DZF;
  logic       SF;
  logic       ZF;

  int checks = 0;
  int errors = 0;

  rem_recon dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .Q    (Q),
    .B    (B),
    .R    (R),
    .P    (P),
    .busy (busy),
    .done (done),
    .DZF  (DZF),
    .SF   (SF),
    .ZF   (ZF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    int b;
    int r;
    int p;
    bit sf;
    bit zf;
    bit dzf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pval();
    logic signed [5:0] s;
    s = P;
    return int'(s);
  endfunction

  function automatic int model_p(input int q, input int b, input int r);
    if (b == 0) return 0;
    return q * b + r;
  endfunction

  task automatic scramble();
    Q = 3'($urandom);
    B = 3'($urandom);
    R = 5'($urandom);
  endtask

  task automatic run_op(input int q, input int b, input int r,
                        input bit scr, input bit timing);
    int  n;
    bit  seen;
    bit  busy_ok;
    int  ep;
    logic [5:0] e6;
    @(negedge clk);
    Q = q[2:0];
    B = b[2:0];
    R = r[4:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scr) scramble();
    n = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (scr) scramble();
      if (n <= 3 && busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    ep = model_p(q, b, r);
    e6 = ep[5:0];
    if (timing) begin
      chk("latency", n, 4);
      chk("busy_in_calc", int'(busy_ok), 1);
      chk("busy_at_done", int'(busy), 0);
    end else if (n != 4) begin
      chk("latency", n, 4);
    end
    chk($sformatf("P q=%0d b=%0d r=%0d", q, b, r), pval(), ep);
    if (timing) begin
      chk("SF", int'(SF), int'(e6[5]));
      chk("ZF", int'(ZF), int'(ep == 0));
      chk("DZF", int'(DZF), int'(b == 0));
    end
    @(posedge clk);
    #1;
    if (timing) chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    vecs[0] = '{q:  3, b:  2, r:   1, p:   7, sf: 0, zf: 0, dzf: 0};
    vecs[1] = '{q: -4, b: -4, r:  15, p:  31, sf: 0, zf: 0, dzf: 0};
    vecs[2] = '{q: -4, b:  3, r: -16, p: -28, sf: 1, zf: 0, dzf: 0};
    vecs[3] = '{q:  2, b:  0, r:   5, p:   0, sf: 0, zf: 1, dzf: 1};
    vecs[4] = '{q:  1, b: -1, r:   1, p:   0, sf: 0, zf: 1, dzf: 0};
    vecs[5] = '{q: -1, b:  3, r:  -2, p:  -5, sf: 1, zf: 0, dzf: 0};

    rst_n = 1'b0;
    start = 1'b0;
    Q = '0;
    B = '0;
    R = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_P", int'(P), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({DZF, SF, ZF}), 0);
    rst_n = 1'b1;

    // table vectors with hand-derived results
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].q, vecs[i].b, vecs[i].r, 1'b0, 1'b1);
      chk($sformatf("vec%0d_P", i), pval(), vecs[i].p);
      chk($sformatf("vec%0d_SF", i), int'(SF), int'(vecs[i].sf));
      chk($sformatf("vec%0d_ZF", i), int'(ZF), int'(vecs[i].zf));
      chk($sformatf("vec%0d_DZF", i), int'(DZF), int'(vecs[i].dzf));
      // result must persist through idle cycles
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold", i), pval(), vecs[i].p);
    end

    // exhaustive sweep of all operand combinations
    for (int q = -4; q <= 3; q++)
      for (int b = -4; b <= 3; b++)
        for (int r = -16; r <= 15; r++)
          run_op(q, b, r, 1'b0, 1'b0);

    // randomized ops with inputs scrambled after capture
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(7) - 4, $urandom_range(7) - 4,
             $urandom_range(31) - 16, 1'b1, 1'b1);
    end

    // reset in the 2nd CALC cycle aborts the op
    run_op(3, 3, 0, 1'b0, 1'b0);
    @(negedge clk);
    Q = 3'd2;
    B = 3'd3;
    R = 5'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_P", int'(P), 0);
    begin
      bit any_done;
      any_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) any_done = 1'b1;
      end
      chk("abort_no_done", int'(any_done), 0);
    end

    // start coinciding with reset is ignored
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    begin
      bit any;
      any = 1'b0;
      for (int c = 0; c < 7; c++) begin
        @(posedge clk);
        #1;
        if (busy === 1'b1 || done === 1'b1) any = 1'b1;
      end
      chk("rst_start_ignored", int'(any), 0);
    end

    // start held high: one result every 5 cycles, mid-CALC changes ignored
    @(negedge clk);
    Q = 3'd1;
    B = 3'd1;
    R = 5'd0;
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (c % 5 == 4) begin
        chk($sformatf("stream_done_c%0d", c), int'(done), 1);
        chk($sformatf("stream_P_c%0d", c), pval(), 1);
      end else begin
        chk($sformatf("stream_idle_c%0d", c), int'(done), 0);
      end
      if (c % 5 <= 2) begin
        scramble();
      end else begin
        Q = 3'd1;
        B = 3'd1;
        R = 5'd0;
      end
    end
    start = 1'b0;
    repeat (6) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rem_recon.md
REM_RECON -- requirements
Module: rem_recon

Interface
REQ-001 The block SHALL have the following ports, in this order (signed values are two's complement):
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- Q  input  3  signed quotient, -4..3.
- B  input  3  signed divisor, -4..3.
- R  input  5  signed remainder, -16..15.
- P  output  6  signed reconstructed dividend, P = Q*B + R.
- busy  output  1  high while computing.
- done  output  1  one-cycle result strobe.
- DZF  output  1  divide-by-zero flag: B was 0.
- SF  output  1  sign flag, equal to P[5].
- ZF  output  1  zero flag: P == 0.
REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The block SHALL implement a state machine with three states: IDLE, CALC and DONE.
REQ-004 In IDLE, when start=1, the block SHALL capture Q, B and R into internal registers, clear the accumulator and the iteration counter, and enter CALC.
REQ-005 In IDLE, when start=0, the block SHALL remain in IDLE.
REQ-006 CALC SHALL last exactly 3 cycles (counter 0..2). In iteration i, when bit i of |Q| is 1, the block SHALL add |B| shifted left by i to the unsigned accumulator. |Q| and |B| are 3-bit unsigned magnitudes, so |-4| = 4.
REQ-007 After the third CALC cycle, the block SHALL enter DONE and register the outputs:
- P = (sign(Q) XOR sign(B) ? -acc : acc) + sign-extended R, computed in 6 bits;
- SF = P[5];
- ZF = (P == 0);
- DZF = (B == 0).
REQ-008 The range -28..31 fits in 6 bits. Overflow SHALL NOT occur and no overflow flag SHALL exist.
REQ-009 When B == 0, the block SHALL force P = 0, DZF = 1, ZF = 1 and SF = 0, and SHALL keep the same 4-cycle latency.
REQ-010 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE, for one cycle.
REQ-011 DONE SHALL always return to IDLE on the next edge. A start asserted during DONE SHALL be ignored.
REQ-012 start asserted in CALC SHALL be ignored. Q, B and R changing after capture SHALL NOT affect the result.
REQ-013 Latency: when start is sampled at edge k, done SHALL be high from edge k+4 to edge k+5, and busy SHALL be high from edge k+1 to edge k+4.
REQ-014 P, SF, ZF and DZF SHALL hold their last values until the next DONE; they change only on entry to DONE.
REQ-015 The maximum throughput SHALL be one operation per 5 cycles.

Reset
REQ-016 While rst_n = 0 at a rising edge, the block SHALL set state = IDLE and clear the counter, the accumulator, P, busy, done, DZF, SF and ZF to 0.
REQ-017 When reset is asserted during CALC or DONE, the block SHALL abort the operation: no done pulse, and the prior P is lost (P = 0).
REQ-018 When start and rst_n = 0 coincide, reset SHALL take priority and start SHALL be ignored.

Verification
REQ-019 Q=3, B=2, R=1, start pulsed -> busy for 3 cycles, then done=1 with P=000111 (7), SF=0, ZF=0, DZF=0.
REQ-020 Q=-4, B=-4, R=15 -> P=011111 (31), SF=0. Q=-4, B=3, R=-16 -> P=100100 (-28), SF=1, ZF=0.
REQ-021 Q=2, B=0, R=5 -> done after 4 cycles with P=0, DZF=1, ZF=1, SF=0.
REQ-022 Q=1, B=-1, R=1 -> P=0, ZF=1, DZF=0. Exhaustive sweep of all 3x3x5-bit combinations -> P equals the Q*B+R reference for every B != 0.
REQ-023 rst_n pulled low in the 2nd CALC cycle -> next cycle: busy=0, P=0, state IDLE, and no done pulse follows.
REQ-024 start held high continuously with Q=1, B=1, R=0 -> done every 5th cycle, P=1; inputs changed mid-CALC do not alter P.
